// File: rtl/nios_iterative_div_cell_if.sv
// rtl/nios_iterative_div_cell_if.sv - start/result handshake between the core and the divide cell
interface nios_iterative_div_cell_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/nios_iterative_div_cell.sv
// rtl/nios_iterative_div_cell.sv - radix-2 restoring divider, one quotient bit per clock
module nios_iterative_div_cell #(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  nios_iterative_div_cell_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  // dvd_q doubles as the quotient register: dividend bits shift out the top while quotient bits enter the bottom
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    cnt_d       = cnt_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;

    shifted = {rem_q, dvd_q[WIDTH-1]};
    trial   = shifted - {1'b0, dsr_q};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dvd_d   = magnitude(bus.dividend, bus.is_signed);
          dsr_d   = magnitude(bus.divisor, bus.is_signed);
          negq_d  = bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
          negr_d  = bus.is_signed & bus.dividend[WIDTH-1];
          zero_d  = (bus.divisor == '0);
          cnt_d   = CW'(WIDTH - 1);
          rem_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        // with a zero divisor every trial succeeds, so rem_q already holds |dividend|
        quotient_d  = zero_q ? '1 : (negq_q ? (~dvd_q + WIDTH'(1)) : dvd_q);
        remainder_d = negr_q ? (~rem_q + WIDTH'(1)) : rem_q;
        dbz_d       = zero_q;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      cnt_q       <= '0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      cnt_q       <= cnt_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_nios_iterative_div_cell.sv
// tb/tb_nios_iterative_div_cell.sv - scoreboard bench for the iterative divide cell
module tb_nios_iterative_div_cell;
  localparam int WIDTH   = 32;
  localparam int LAT     = WIDTH + 1;
  localparam int BUSY_N  = WIDTH + 1;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
    int               done_cyc;
    string            name;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;
  int   busy_run;
  logic prev_done;
  exp_t sb[$];

  nios_iterative_div_cell_if #(.WIDTH(WIDTH)) dif ();

  nios_iterative_div_cell #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%h required=0x%h", nm, act, exp);
    end
  endtask

  // monitor: pops the scoreboard whenever the cell reports done
  initial begin
    busy_run  = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_run  = 0;
        prev_done = 1'b0;
      end else begin
        if (prev_done) chk("done_one_cycle", {31'b0, dif.done}, 32'd0);
        if (dif.done) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, "_q"}, dif.quotient, e.q);
            chk({e.name, "_r"}, dif.remainder, e.r);
            chk({e.name, "_dbz"}, {31'b0, dif.div_by_zero}, {31'b0, e.dbz});
            chk({e.name, "_latency"}, cyc, e.done_cyc);
            chk({e.name, "_busy_len"}, busy_run, BUSY_N);
            chk({e.name, "_busy_in_done"}, {31'b0, dif.busy}, 32'd0);
          end
          busy_run = 0;
        end else if (dif.busy) begin
          busy_run++;
        end
        prev_done = dif.done;
      end
    end
  end

  // call on a negedge; returns on the negedge after the accepting edge
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sgn,
                       input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er, input logic edbz,
                       input string nm, input bit push);
    exp_t e;
    dif.dividend  = a;
    dif.divisor   = b;
    dif.is_signed = sgn;
    dif.start     = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      e.q        = eq;
      e.r        = er;
      e.dbz      = edbz;
      e.done_cyc = cyc + LAT;
      e.name     = nm;
      sb.push_back(e);
    end
    @(negedge clk);
    dif.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || dif.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL wait_idle_timeout actual=%0d required<200 pending=%0d", n, sb.size());
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    total         = 0;
    bad           = 0;
    reset         = 1'b1;
    dif.start     = 1'b0;
    dif.is_signed = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, dif.busy}, 32'd0);
    chk("rst_done", {31'b0, dif.done}, 32'd0);
    chk("rst_q", dif.quotient, 32'd0);
    chk("rst_r", dif.remainder, 32'd0);
    chk("rst_dbz", {31'b0, dif.div_by_zero}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, "u100_7", 1'b1);
    wait_idle();
    issue(-32'sd100, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, "sm100_7", 1'b1);
    wait_idle();
    issue(32'd100, -32'sd7, 1'b1, 32'hFFFF_FFF2, 32'd2, 1'b0, "s100_m7", 1'b1);
    wait_idle();
    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, "umax_1", 1'b1);
    wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, "smin_m1", 1'b1);
    wait_idle();
    issue(32'd1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd1234, 1'b1, "u1234_0", 1'b1);
    wait_idle();
    issue(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, "sm5_0", 1'b1);
    wait_idle();

    // start during a busy operation must be ignored
    issue(-32'sd100, -32'sd7, 1'b1, 32'd14, 32'hFFFF_FFFE, 1'b0, "sm100_m7", 1'b1);
    repeat (8) @(negedge clk);
    dif.dividend  = 32'd9999;
    dif.divisor   = 32'd1;
    dif.is_signed = 1'b0;
    dif.start     = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    wait_idle();

    // back-to-back: second start lands in the done cycle of the first
    issue(32'd500, 32'd3, 1'b0, 32'd166, 32'd2, 1'b0, "u500_3", 1'b1);
    n = 0;
    while (!dif.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL b2b_done_timeout actual=%0d required<100", n);
    end
    issue(32'd9, 32'd2, 1'b0, 32'd4, 32'd1, 1'b0, "b2b_9_2", 1'b1);
    wait_idle();

    // asynchronous reset mid-operation
    issue(32'd30, 32'd3, 1'b0, 32'd10, 32'd0, 1'b0, "rst30_3", 1'b0);
    repeat (13) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'b0, dif.busy}, 32'd0);
    chk("mid_rst_done", {31'b0, dif.done}, 32'd0);
    chk("mid_rst_q", dif.quotient, 32'd0);
    chk("mid_rst_r", dif.remainder, 32'd0);
    chk("mid_rst_dbz", {31'b0, dif.div_by_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (45) @(negedge clk);
    chk("post_rst_idle", {31'b0, dif.busy}, 32'd0);
    issue(32'd30, 32'd3, 1'b0, 32'd10, 32'd0, 1'b0, "u30_3", 1'b1);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required<200000", $time);
    $fatal(1, "timeout");
  end
endmodule
